// File: rtl/dual_port_reg_file_pkg.sv
// Shared geometry defaults and bus payload types for the dual-port register file.
package dual_port_reg_file_pkg;

    localparam int unsigned RF_DATA_WIDTH = 8;
    localparam int unsigned RF_ADDR_WIDTH = 15;
    localparam int unsigned RF_DEPTH      = 2 ** RF_ADDR_WIDTH;

    typedef logic [RF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [RF_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/dual_port_reg_file_if.sv
// Write/read port bundle of the register file; master drives requests, slave returns read data.
interface dual_port_reg_file_if
    import dual_port_reg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
);

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output wr_en, wr_addr, data_in, rd_en, rd_addr,
        input  data_out
    );

    modport slave (
        input  wr_en, wr_addr, data_in, rd_en, rd_addr,
        output data_out
    );

endinterface

// File: rtl/dual_port_reg_file_mem_array.sv
// Un-reset storage array with synchronous write and combinational read, kept plain for RAM inference.
module regfile_mem_array #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data_c
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data_c = r_mem[i_rd_addr];

endmodule

// File: rtl/dual_port_reg_file.sv
// Simple dual-port register file: range-checked write into the array, registered reset-able read.
module dual_port_reg_file
    import dual_port_reg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    dual_port_reg_file_if.slave       bus
);

    localparam bit FULL_RANGE = (DEPTH == (2 ** ADDR_WIDTH));

    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_mem_rd_data;
    logic [DATA_WIDTH-1:0] r_data_out;

    // Range checks collapse to constants when every address maps to an entry.
    generate
        if (FULL_RANGE) begin : g_full_range
            assign w_wr_in_range = 1'b1;
            assign w_rd_in_range = 1'b1;
        end else begin : g_partial_range
            assign w_wr_in_range = (32'(bus.wr_addr) < DEPTH);
            assign w_rd_in_range = (32'(bus.rd_addr) < DEPTH);
        end
    endgenerate

    assign w_wr_en = reset & bus.wr_en & w_wr_in_range;

    regfile_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk         (clk),
        .i_wr_en     (w_wr_en),
        .i_wr_addr   (bus.wr_addr),
        .i_wr_data   (bus.data_in),
        .i_rd_addr   (bus.rd_addr),
        .o_rd_data_c (w_mem_rd_data)
    );

    // Array read is sampled before the same-edge write lands, giving read-before-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_out <= '0;
        end else if (bus.rd_en) begin
            r_data_out <= w_rd_in_range ? w_mem_rd_data : '0;
        end
    end

    assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_dual_port_reg_file.sv
// Directed self-checking bench for dual_port_reg_file with hand-computed expected read data.
module tb_dual_port_reg_file;
    import dual_port_reg_file_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    dual_port_reg_file_if u_if ();

    dual_port_reg_file u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input data_t obs, input data_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input addr_t addr, input data_t data);
        u_if.wr_en   = 1'b1;
        u_if.wr_addr = addr;
        u_if.data_in = data;
        tick();
        u_if.wr_en   = 1'b0;
    endtask

    task automatic do_read(input string tag, input addr_t addr, input data_t exp);
        u_if.rd_en   = 1'b1;
        u_if.rd_addr = addr;
        tick();
        u_if.rd_en   = 1'b0;
        check_val(tag, u_if.data_out, exp);
    endtask

    initial begin
        addr_t hold_addrs [4];
        n_checks = 0;
        n_errors = 0;
        hold_addrs[0] = 15'd1;
        hold_addrs[1] = 15'd32767;
        hold_addrs[2] = 15'd5;
        hold_addrs[3] = 15'd100;

        reset        = 1'b0;
        u_if.wr_en   = 1'b0;
        u_if.rd_en   = 1'b0;
        u_if.wr_addr = '0;
        u_if.rd_addr = '0;
        u_if.data_in = '0;

        #2;
        check_val("reset_async", u_if.data_out, 8'h00);
        tick();
        check_val("reset_held", u_if.data_out, 8'h00);
        reset = 1'b1;
        tick();
        tick();
        check_val("after_reset", u_if.data_out, 8'h00);

        do_write(15'd0, 8'hAA);
        do_read("rd_addr0", 15'd0, 8'hAA);

        do_write(15'd1, 8'hBB);
        do_read("rd_addr1", 15'd1, 8'hBB);
        do_read("rd_addr0_again", 15'd0, 8'hAA);

        do_write(15'd32767, 8'hCC);
        do_read("rd_addr_max", 15'd32767, 8'hCC);
        do_read("rd_addr0_no_alias", 15'd0, 8'hAA);

        // Same edge, same address: old content is returned.
        do_write(15'd5, 8'h22);
        u_if.wr_en   = 1'b1;
        u_if.wr_addr = 15'd5;
        u_if.data_in = 8'h11;
        u_if.rd_en   = 1'b1;
        u_if.rd_addr = 15'd5;
        tick();
        u_if.wr_en   = 1'b0;
        u_if.rd_en   = 1'b0;
        check_val("rbw_old", u_if.data_out, 8'h22);
        do_read("rbw_new", 15'd5, 8'h11);

        // Same edge, different addresses.
        u_if.wr_en   = 1'b1;
        u_if.wr_addr = 15'd6;
        u_if.data_in = 8'h33;
        u_if.rd_en   = 1'b1;
        u_if.rd_addr = 15'd1;
        tick();
        u_if.wr_en   = 1'b0;
        u_if.rd_en   = 1'b0;
        check_val("indep_rd", u_if.data_out, 8'hBB);
        do_read("indep_wr", 15'd6, 8'h33);

        for (int i = 0; i < 4; i++) begin
            u_if.rd_addr = hold_addrs[i];
            tick();
            check_val("hold", u_if.data_out, 8'h33);
        end

        // Back-to-back reads with rd_en held high.
        u_if.rd_en   = 1'b1;
        u_if.rd_addr = 15'd0;
        tick();
        check_val("b2b_0", u_if.data_out, 8'hAA);
        u_if.rd_addr = 15'd32767;
        tick();
        check_val("b2b_max", u_if.data_out, 8'hCC);
        u_if.rd_addr = 15'd1;
        tick();
        check_val("b2b_1", u_if.data_out, 8'hBB);

        // Mid-stream reset with a read and a write pending.
        u_if.rd_addr = 15'd5;
        u_if.wr_en   = 1'b1;
        u_if.wr_addr = 15'd0;
        u_if.data_in = 8'h55;
        #2;
        reset = 1'b0;
        #1;
        check_val("reset_mid_async", u_if.data_out, 8'h00);
        tick();
        check_val("reset_mid_ignored", u_if.data_out, 8'h00);
        u_if.wr_en = 1'b0;
        u_if.rd_en = 1'b0;
        reset      = 1'b1;
        tick();
        check_val("reset_mid_release", u_if.data_out, 8'h00);
        do_read("preserved_addr0", 15'd0, 8'hAA);
        do_read("preserved_addr5", 15'd5, 8'h11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dual_port_reg_file.md
Name: dual_port_reg_file

Overview:
- Simple dual-port synchronous register file: one write port and one read port, both on a single clock.
- Default geometry is 32768 x 8 bit (15-bit addresses).
- Serves as the byte-addressable storage behind the interface block; one side writes while the other reads independently.
- Read data is registered, so it appears one clock after the read request.

Parameters:
- DATA_WIDTH, 8, width of each entry and of data_in/data_out.
- ADDR_WIDTH, 15, width of wr_addr and rd_addr.
- DEPTH, 2**ADDR_WIDTH (32768), number of entries; must be <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write enable, sampled on rising clk.
- rd_en  input  1  read enable, sampled on rising clk.
- wr_addr  input  ADDR_WIDTH  write address.
- data_in  input  DATA_WIDTH  write data.
- rd_addr  input  ADDR_WIDTH  read address.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous-to-clk release): data_out clears to 0 immediately.
  - Storage array is NOT cleared.
  - wr_en/rd_en are ignored while reset=0.
- Write: on rising clk with reset=1 and wr_en=1, mem[wr_addr] <= data_in.
  - Data is visible to a read sampled on any later edge.
- Read: on rising clk with reset=1 and rd_en=1, data_out <= mem[rd_addr]; latency is 1 clock.
  - With rd_en=0, data_out holds its previous value.
- Same-edge read and write to the same address: read-before-write; data_out gets the old content, and the new data is readable from the next edge.
- Same-edge read and write to different addresses: fully independent.
- Out-of-range address (>= DEPTH, only possible when DEPTH < 2**ADDR_WIDTH):
  - Write is dropped.
  - Read loads data_out with 0.
- Never-written entries after power-up: content undefined; verification must not check them.
- Reset asserted mid-operation: any in-flight read is discarded (data_out=0); stored entries are preserved.
- Boundary addresses 0 and DEPTH-1 (32767) must be fully usable; no wrap or aliasing.
- No handshake or busy signal: one write and one read can be accepted every cycle, back-to-back.

Decomposition:
- Shared package: DATA_WIDTH/ADDR_WIDTH defaults, and typedefs addr_t (logic [ADDR_WIDTH-1:0]) and data_t (logic [DATA_WIDTH-1:0]).
- Natural single sub-module: regfile_mem_array, holding the un-reset storage array plus the write logic.
  - Keeps it inferable as block RAM.
  - Top level contains the registered, reset-able read output and the range checks.

Test Plan:
- Reset: drive reset=0 for 1 cycle, then reset=1 -> data_out = 0x00 during and after reset, until the first read.
- Write 0xAA to addr 0 (one cycle wr_en=1), then rd_en=1, rd_addr=0 -> data_out = 0xAA one clock later.
- Write 0xBB to addr 1, then read addr 1 -> data_out = 0xBB one clock later; addr 0 still reads 0xAA.
- Write 0xCC to addr 32767, then read addr 32767 -> data_out = 0xCC; addr 0 still 0xAA (no aliasing).
- Same edge: wr_en=1 to addr 5 with 0x11 (previously holding 0x22) and rd_en=1 on addr 5 -> data_out = 0x22, next read = 0x11.
- rd_en=0 with a changing rd_addr -> data_out holds its last value; asserting reset mid-stream -> data_out = 0 immediately, and previously written 0xAA at addr 0 is still readable afterwards.
